// File: rtl/inverse_loader_if.sv
// Element streaming bus for inverse_loader: matrix elements in, inverse elements out.
// slave = loader side, master = producer/consumer side.
interface inverse_loader_if #(
  parameter int WIDTH = 27
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/inverse_loader.sv
// Loads an N x N matrix row-major, runs the inversion stage for COMPUTE_CYCLES, then streams the inverse out.
// Define INVERSE_LOADER_ABORT_EN to add a synchronous abort input that returns the FSM to LOAD.
module inverse_loader #(
  parameter int WIDTH          = 27,
  parameter int N              = 6,
  parameter int COMPUTE_CYCLES = 200
) (
  input  logic                             clk,
  input  logic                             rst,
`ifdef INVERSE_LOADER_ABORT_EN
  input  logic                             abort,
`endif
  inverse_loader_if.slave                  bus,
  output logic                             inv_en,
  output logic                             inv_rst,
  output logic [7:0]                       count,
  output logic [N-1:0][N-1:0][WIDTH-1:0]   matrix,
  input  logic [N-1:0][N-1:0][WIDTH-1:0]   inverse
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [7:0]       CNT_LAST = 8'(COMPUTE_CYCLES - 1);

  localparam logic [1:0] S_LOAD    = 2'd0;
  localparam logic [1:0] S_CLEAR   = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_UNLOAD  = 2'd3;

  logic [1:0]                       state_q, state_d;
  logic [IDX_W-1:0]                 row_q, row_d;
  logic [IDX_W-1:0]                 col_q, col_d;
  logic [7:0]                       count_q, count_d;
  logic [N-1:0][N-1:0][WIDTH-1:0]   matrix_q, matrix_d;
  logic [N-1:0][N-1:0][WIDTH-1:0]   buffer_q, buffer_d;

  logic             in_fire;
  logic             out_fire;
  logic             pos_last;
  logic [IDX_W-1:0] row_nx;
  logic [IDX_W-1:0] col_nx;

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.out_valid = (state_q == S_UNLOAD);
  assign in_fire       = bus.in_valid  & bus.in_ready;
  assign out_fire      = bus.out_valid & bus.out_ready;

  assign inv_en  = (state_q == S_COMPUTE);
  assign inv_rst = (state_q == S_CLEAR);
  assign count   = count_q;
  assign matrix  = matrix_q;

  // Row-major walk shared by the load and unload phases.
  always_comb begin
    pos_last = (row_q == IDX_LAST) && (col_q == IDX_LAST);
    row_nx   = row_q;
    col_nx   = col_q + 1'b1;
    if (col_q == IDX_LAST) begin
      col_nx = '0;
      row_nx = pos_last ? '0 : row_q + 1'b1;
    end
  end

  always_comb begin
    bus.out_data = '0;
    bus.out_last = 1'b0;
    if (state_q == S_UNLOAD) begin
      bus.out_data = buffer_q[row_q][col_q];
      bus.out_last = pos_last;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    count_d  = '0;
    matrix_d = matrix_q;
    buffer_d = buffer_q;
    case (state_q)
      S_LOAD: begin
        if (in_fire) begin
          matrix_d[row_q][col_q] = bus.in_data;
          row_d = row_nx;
          col_d = col_nx;
          if (pos_last) state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (count_q == CNT_LAST) begin
          buffer_d = inverse;
          state_d  = S_UNLOAD;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      S_UNLOAD: begin
        if (out_fire) begin
          row_d = row_nx;
          col_d = col_nx;
          if (pos_last) state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_LOAD;
        row_d   = '0;
        col_d   = '0;
      end
    endcase
`ifdef INVERSE_LOADER_ABORT_EN
    // Abort wins over any handshake in the same cycle; stored data is kept.
    if (abort) begin
      state_d  = S_LOAD;
      row_d    = '0;
      col_d    = '0;
      count_d  = '0;
      matrix_d = matrix_q;
      buffer_d = buffer_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_LOAD;
      row_q    <= '0;
      col_q    <= '0;
      count_q  <= '0;
      matrix_q <= '0;
      buffer_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      count_q  <= count_d;
      matrix_q <= matrix_d;
      buffer_q <= buffer_d;
    end
  end

endmodule

// File: tb/tb_inverse_loader.sv
// Directed bench for inverse_loader: load, compute timing, unload with stalls, async reset, optional abort.
module tb_inverse_loader;
  localparam int WIDTH = 27;
  localparam int N     = 6;
  localparam int NN    = N * N;

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           abort;
  logic                           inv_en;
  logic                           inv_rst;
  logic [7:0]                     count;
  logic [N-1:0][N-1:0][WIDTH-1:0] matrix;
  logic [N-1:0][N-1:0][WIDTH-1:0] inverse;

  int checks = 0;
  int errors = 0;

  inverse_loader_if #(.WIDTH(WIDTH)) bus ();

  inverse_loader #(.WIDTH(WIDTH), .N(N), .COMPUTE_CYCLES(200)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef INVERSE_LOADER_ABORT_EN
    .abort   (abort),
`endif
    .bus     (bus.slave),
    .inv_en  (inv_en),
    .inv_rst (inv_rst),
    .count   (count),
    .matrix  (matrix),
    .inverse (inverse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic set_inverse(input int base);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        inverse[r][c] = WIDTH'(base + r * N + c);
  endtask

  task automatic load(input int base, input bit gaps);
    for (int i = 0; i < NN; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(base + i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_compute(output int en_cyc, output int pulses, output bit cnt_ok);
    en_cyc = 0;
    pulses = 0;
    cnt_ok = 1'b1;
    for (int t = 0; t < 1000 && !bus.out_valid; t++) begin
      if (inv_rst) pulses++;
      if (inv_en) begin
        if (count != 8'(en_cyc)) cnt_ok = 1'b0;
        en_cyc++;
      end else if (count != 8'd0) begin
        cnt_ok = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("compute_done", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic unload(input int base, input bit stall);
    int               got;
    bit               prev_stall;
    logic [WIDTH-1:0] prev_data;
    logic             prev_last;
    got        = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    for (int t = 0; t < 400 && got < NN; t++) begin
      bus.out_ready = stall ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
      if (prev_stall) begin
        chk($sformatf("stall_data_%0d", got), 64'(bus.out_data), 64'(prev_data));
        chk($sformatf("stall_last_%0d", got), 64'(bus.out_last), 64'(prev_last));
      end
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("out_data_%0d", got), 64'(bus.out_data), 64'(base + got));
        chk($sformatf("out_last_%0d", got), 64'(bus.out_last), 64'(got == NN - 1));
        got++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    chk("unload_count", 64'(got), 64'(NN));
    chk("post_unload_valid", 64'(bus.out_valid), 64'd0);
    chk("post_unload_ready", 64'(bus.in_ready), 64'd1);
  endtask

  int en_cyc;
  int pulses;
  bit cnt_ok;

  initial begin
    rst           = 1'b0;
    abort         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    set_inverse(100);
    repeat (3) @(posedge clk);
    #1;

    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_last",  64'(bus.out_last),  64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    chk("rst_inv_en",    64'(inv_en),        64'd0);
    chk("rst_inv_rst",   64'(inv_rst),       64'd0);
    chk("rst_count",     64'(count),         64'd0);
    chk("rst_matrix_nz", 64'(matrix != '0),  64'd0);

    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Back-to-back load of 1..36, then compute with in_valid left high
    load(1, 1'b0);
    chk("ready_after_load", 64'(bus.in_ready), 64'd0);
    chk("m00", 64'(matrix[0][0]), 64'd1);
    chk("m05", 64'(matrix[0][5]), 64'd6);
    chk("m10", 64'(matrix[1][0]), 64'd7);
    chk("m55", 64'(matrix[5][5]), 64'd36);
    bus.in_valid = 1'b1;
    bus.in_data  = WIDTH'(999);
    run_compute(en_cyc, pulses, cnt_ok);
    bus.in_valid = 1'b0;
    chk("en_cycles",     64'(en_cyc), 64'd200);
    chk("inv_rst_pulse", 64'(pulses), 64'd1);
    chk("count_seq",     64'(cnt_ok), 64'd1);
    chk("m00_held",      64'(matrix[0][0]), 64'd1);
    unload(100, 1'b0);

    // Gapped load and stalled unload
    set_inverse(300);
    load(200, 1'b1);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        chk($sformatf("gap_m%0d%0d", r, c), 64'(matrix[r][c]), 64'(200 + r * N + c));
    run_compute(en_cyc, pulses, cnt_ok);
    chk("gap_en_cycles", 64'(en_cyc), 64'd200);
    unload(300, 1'b1);

    // Asynchronous reset in the middle of compute
    load(1, 1'b0);
    for (int t = 0; t < 400 && !(inv_en && count == 8'd50); t++) begin
      @(posedge clk); #1;
    end
    chk("reach_count50", 64'(count), 64'd50);
    rst = 1'b0;
    #1;
    chk("mid_rst_inv_en",   64'(inv_en),       64'd0);
    chk("mid_rst_count",    64'(count),        64'd0);
    chk("mid_rst_matrix",   64'(matrix != '0), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    set_inverse(400);
    load(600, 1'b0);
    chk("reload_m55", 64'(matrix[5][5]), 64'd635);
    run_compute(en_cyc, pulses, cnt_ok);
    chk("reload_en_cycles", 64'(en_cyc), 64'd200);
    unload(400, 1'b0);

`ifdef INVERSE_LOADER_ABORT_EN
    begin
      int got;
      set_inverse(700);
      load(500, 1'b0);
      run_compute(en_cyc, pulses, cnt_ok);
      got = 0;
      bus.out_ready = 1'b1;
      for (int t = 0; t < 100 && got < 10; t++) begin
        if (bus.out_valid && bus.out_ready) begin
          chk($sformatf("abort_data_%0d", got), 64'(bus.out_data), 64'(700 + got));
          got++;
        end
        @(posedge clk); #1;
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      bus.out_ready = 1'b0;
      chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
      chk("abort_in_ready",  64'(bus.in_ready),  64'd1);
      chk("abort_count",     64'(count),         64'd0);
      chk("abort_m00",       64'(matrix[0][0]),  64'd500);
      chk("abort_m55",       64'(matrix[5][5]),  64'd535);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
